spi_flash_copier: RTL and testbench

- Boot/DMA sequencer that drives the SPI byte engine to read a block from external SPI flash (READ, 0x03) and write it word-by-word into SoC memory as a bus master.
- Sits between the SPI controller (byte-level TX/RX with valid/ready) and the SoC bus, beside the CPU.
- Used to copy firmware from flash into RAM before the CPU is released, or on request from a memory-mapped register.
- Owns SPI chip select for the duration of a transfer.

---
 rtl/spi_flash_copier.sv | 164 ++++++++++++++++
 tb/tb_spi_flash_copier.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_copier.sv
// Sends a flash READ command, then packs the returned bytes little-endian into
// 32-bit words and writes each word to the SoC bus before the next SPI byte.
module spi_flash_copier #(
  parameter int unsigned CS_GAP   = 4,
  parameter logic [7:0]  CMD_READ = 8'h03
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] flashAddress,
  input  logic [31:0] destAddress,
  input  logic [15:0] wordCount,
  output logic        busy,
  output logic        done,
  output logic [7:0]  spiDataTx,
  output logic        spiValid,
  input  logic [7:0]  spiDataRx,
  input  logic        spiReady,
  output logic        spiCSn,
  output logic [31:0] busAddress,
  output logic [31:0] busDataOut,
  output logic        busValid,
  output logic        busWriteEnable,
  input  logic        busReady
);

  localparam int unsigned GapW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'(CS_GAP - 1);

  typedef enum logic [2:0] {
    IDLE, GAP, SEND, WAIT_LOW, WAIT_HIGH, WRITE, FINISH
  } state_t;

  state_t state, stateNext;

  logic [23:0]     flashAddrQ;
  logic [31:0]     destQ;
  logic [15:0]     remaining;
  logic [31:0]     word;
  logic [2:0]      byteCnt;
  logic [1:0]      lane;
  logic            lowSeen;
  logic [GapW-1:0] gapCnt;

  logic       acceptStart, emptyStart, gapDone, sendByte, byteDone;
  logic       isData, wordDone, writeAccept, lastWord;
  logic [7:0] txByte;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:      if (acceptStart) stateNext = GAP;
      GAP:       if (gapDone) stateNext = SEND;
      SEND:      if (sendByte) stateNext = WAIT_LOW;
      WAIT_LOW: begin
        if (!spiReady)     stateNext = WAIT_HIGH;
        else if (byteDone) stateNext = wordDone ? WRITE : SEND;
      end
      WAIT_HIGH: if (byteDone) stateNext = wordDone ? WRITE : SEND;
      WRITE:     if (writeAccept) stateNext = lastWord ? FINISH : SEND;
      FINISH:    stateNext = IDLE;
      default:   stateNext = IDLE;
    endcase
  end

  // Control strobes and outgoing byte selection
  always_comb begin
    acceptStart = (state == IDLE) && start && (wordCount != 16'd0);
    emptyStart  = (state == IDLE) && start && (wordCount == 16'd0);
    gapDone     = (state == GAP) && (gapCnt == GapLast);
    sendByte    = (state == SEND) && spiReady;
    // A byte that never pulls spiReady low for two cycles counts as finished.
    byteDone    = ((state == WAIT_LOW) && spiReady && lowSeen) ||
                  ((state == WAIT_HIGH) && spiReady);
    isData      = (byteCnt == 3'd4);
    wordDone    = byteDone && isData && (lane == 2'd3);
    writeAccept = (state == WRITE) && busReady;
    lastWord    = (remaining == 16'd1);
    txByte      = 8'h00;
    case (byteCnt)
      3'd0:    txByte = CMD_READ;
      3'd1:    txByte = flashAddrQ[23:16];
      3'd2:    txByte = flashAddrQ[15:8];
      3'd3:    txByte = flashAddrQ[7:0];
      default: txByte = 8'h00;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      spiCSn     <= 1'b1;
      spiValid   <= 1'b0;
      spiDataTx  <= 8'h00;
      busValid   <= 1'b0;
      busAddress <= 32'h0;
      busDataOut <= 32'h0;
      flashAddrQ <= 24'h0;
      destQ      <= 32'h0;
      remaining  <= 16'h0;
      word       <= 32'h0;
      byteCnt    <= 3'd0;
      lane       <= 2'd0;
      lowSeen    <= 1'b0;
      gapCnt     <= '0;
    end else begin
      done     <= 1'b0;
      spiValid <= 1'b0;
      if (acceptStart) begin
        busy       <= 1'b1;
        flashAddrQ <= flashAddress;
        destQ      <= destAddress & 32'hFFFF_FFFC;
        remaining  <= wordCount;
        byteCnt    <= 3'd0;
        lane       <= 2'd0;
        gapCnt     <= '0;
      end
      if (emptyStart) done <= 1'b1;
      if (state == GAP) gapCnt <= gapCnt + GapW'(1);
      if (gapDone) spiCSn <= 1'b0;
      if (sendByte) begin
        spiValid  <= 1'b1;
        spiDataTx <= txByte;
        lowSeen   <= 1'b0;
      end
      if ((state == WAIT_LOW) && spiReady) lowSeen <= 1'b1;
      if (byteDone) begin
        if (!isData) begin
          byteCnt <= byteCnt + 3'd1;
        end else begin
          word <= {spiDataRx, word[31:8]};
          lane <= lane + 2'd1;
        end
      end
      if (wordDone) begin
        busValid   <= 1'b1;
        busAddress <= destQ;
        busDataOut <= {spiDataRx, word[31:8]};
      end
      if (writeAccept) begin
        busValid  <= 1'b0;
        destQ     <= destQ + 32'd4;
        remaining <= remaining - 16'd1;
        if (lastWord) begin
          spiCSn <= 1'b1;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
      end
    end
  end

  assign busWriteEnable = busValid;

endmodule

// File: tb/tb_spi_flash_copier.sv
// Scoreboard bench: expected SPI bytes, bus writes and done pulses are queued
// by the stimulus; a negedge monitor pops and compares as the DUT emits them.
module tb_spi_flash_copier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start;
  logic [23:0] flashAddress;
  logic [31:0] destAddress;
  logic [15:0] wordCount;
  logic        busy, done, spiValid, spiReady, spiCSn;
  logic [7:0]  spiDataTx, spiDataRx;
  logic [31:0] busAddress, busDataOut;
  logic        busValid, busWriteEnable, busReady;

  spi_flash_copier dut (
    .clk(clk), .reset(reset), .start(start), .flashAddress(flashAddress),
    .destAddress(destAddress), .wordCount(wordCount), .busy(busy), .done(done),
    .spiDataTx(spiDataTx), .spiValid(spiValid), .spiDataRx(spiDataRx),
    .spiReady(spiReady), .spiCSn(spiCSn), .busAddress(busAddress),
    .busDataOut(busDataOut), .busValid(busValid), .busWriteEnable(busWriteEnable),
    .busReady(busReady)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  expTx[$];
  logic [7:0]  rxQ[$];
  logic [63:0] expW[$];
  int expDone = 0;
  int stall = 0;
  int stalled = 0;
  int txSeen = 0;
  int csHighCnt = 0;
  logic prevCsn = 1'b1;
  logic engBusy = 1'b0;
  int engCnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen with nothing expected", name);
  endtask

  // SPI engine model, bus slave and scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (spiValid) begin
        txSeen++;
        check("spi_engine_idle", 32'(engBusy), 32'd0);
        check("spi_cs_low", 32'(spiCSn), 32'd0);
        if (expTx.size() == 0) unexpected("spi_tx");
        else check("spi_tx", 32'(spiDataTx), 32'(expTx.pop_front()));
        engBusy = 1'b1;
        engCnt = 3;
        spiReady = 1'b0;
      end else if (engBusy) begin
        engCnt--;
        if (engCnt == 0) begin
          engBusy = 1'b0;
          spiReady = 1'b1;
          spiDataRx = (rxQ.size() != 0) ? rxQ.pop_front() : 8'hA5;
        end
      end

      if (busValid) begin
        check("spi_quiet_during_write", 32'(spiValid), 32'd0);
        check("bus_we", 32'(busWriteEnable), 32'd1);
        if (expW.size() == 0) begin
          unexpected("bus_write");
          busReady = 1'b1;
        end else begin
          check("bus_addr", busAddress, expW[0][63:32]);
          check("bus_data", busDataOut, expW[0][31:0]);
          if (stall > 0) begin
            stall--;
            stalled++;
            busReady = 1'b0;
          end else begin
            busReady = 1'b1;
            void'(expW.pop_front());
          end
        end
      end else begin
        busReady = 1'b0;
      end

      if (done) begin
        if (expDone > 0) begin
          expDone--;
          checks++;
        end else unexpected("done");
        check("done_cs_high", 32'(spiCSn), 32'd1);
        check("done_busy_low", 32'(busy), 32'd0);
      end

      if (!busy) begin
        check("idle_cs_high", 32'(spiCSn), 32'd1);
        check("idle_no_spi", 32'(spiValid), 32'd0);
        check("idle_no_bus", 32'(busValid), 32'd0);
        csHighCnt = 0;
      end else if (spiCSn) begin
        csHighCnt++;
      end else if (prevCsn) begin
        check("cs_gap_len", 32'(csHighCnt), 32'd4);
      end
      prevCsn = spiCSn;
    end
  end

  task automatic pushTx(input logic [23:0] fa, input int wc);
    expTx.push_back(8'h03);
    expTx.push_back(fa[23:16]);
    expTx.push_back(fa[15:8]);
    expTx.push_back(fa[7:0]);
    for (int i = 0; i < 4 * wc; i++) expTx.push_back(8'h00);
  endtask

  task automatic pushRx(input logic [7:0] first, input int n);
    for (int i = 0; i < 4; i++) rxQ.push_back(8'hCC);
    for (int i = 0; i < n; i++) rxQ.push_back(first + 8'(i));
  endtask

  task automatic startCopy(input logic [23:0] fa, input logic [31:0] da, input logic [15:0] wc);
    @(negedge clk);
    #1;
    flashAddress = fa;
    destAddress = da;
    wordCount = wc;
    start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = (expDone == 0) && (expW.size() == 0) && (expTx.size() == 0) && !busy;
    end
    check(name, 32'(ok), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    flashAddress = 24'h0;
    destAddress = 32'h0;
    wordCount = 16'h0;
    spiReady = 1'b1;
    spiDataRx = 8'h00;
    busReady = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_csn", 32'(spiCSn), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_spivalid", 32'(spiValid), 32'd0);
    check("rst_busvalid", 32'(busValid), 32'd0);
    check("rst_tx", 32'(spiDataTx), 32'd0);
    check("rst_addr", busAddress, 32'd0);
    check("rst_data", busDataOut, 32'd0);
    #1 reset = 1'b0;

    // Basic two-word copy
    pushTx(24'h100000, 2);
    pushRx(8'h11, 8);
    expW.push_back({32'h0001_0000, 32'h1413_1211});
    expW.push_back({32'h0001_0004, 32'h1817_1615});
    expDone = 1;
    startCopy(24'h100000, 32'h0001_0000, 16'd2);
    waitIdle("basic_complete");

    // Zero-length request
    expDone = 1;
    @(negedge clk);
    #1;
    wordCount = 16'd0;
    start = 1'b1;
    @(negedge clk);
    check("zero_done_next", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    #1 start = 1'b0;
    waitIdle("zero_complete");

    // Bus slave stalls the first write
    stall = 5;
    stalled = 0;
    pushTx(24'h000200, 2);
    pushRx(8'h21, 8);
    expW.push_back({32'h0000_2000, 32'h2423_2221});
    expW.push_back({32'h0000_2004, 32'h2827_2625});
    expDone = 1;
    startCopy(24'h000200, 32'h0000_2000, 16'd2);
    waitIdle("stall_complete");
    check("stall_cycles", 32'(stalled), 32'd5);

    // Reset while the third data byte is in flight
    pushTx(24'h300000, 2);
    pushRx(8'h31, 8);
    txSeen = 0;
    startCopy(24'h300000, 32'h0000_3000, 16'd2);
    begin
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 500 && !hit; i++) begin
        @(negedge clk);
        #1;
        hit = (txSeen >= 7);
      end
      check("reset_reach_byte7", 32'(hit), 32'd1);
    end
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("midrst_csn", 32'(spiCSn), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_busvalid", 32'(busValid), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    #1;
    reset = 1'b0;
    expTx.delete();
    rxQ.delete();
    engBusy = 1'b0;
    spiReady = 1'b1;
    spiDataRx = 8'h00;
    pushTx(24'h300000, 1);
    pushRx(8'h41, 4);
    expW.push_back({32'h0000_3000, 32'h4443_4241});
    expDone = 1;
    startCopy(24'h300000, 32'h0000_3000, 16'd1);
    waitIdle("after_reset_complete");

    // Second start while busy is ignored
    pushTx(24'h400000, 2);
    pushRx(8'h51, 8);
    expW.push_back({32'h0000_4000, 32'h5453_5251});
    expW.push_back({32'h0000_4004, 32'h5857_5655});
    expDone = 1;
    startCopy(24'h400000, 32'h0000_4000, 16'd2);
    repeat (20) @(negedge clk);
    startCopy(24'h222222, 32'h0000_9000, 16'd5);
    waitIdle("restart_ignored_complete");

    // Destination wraps past the top of the address space; low bits dropped
    pushTx(24'h000010, 2);
    pushRx(8'h61, 8);
    expW.push_back({32'hFFFF_FFFC, 32'h6463_6261});
    expW.push_back({32'h0000_0000, 32'h6867_6665});
    expDone = 1;
    startCopy(24'h000010, 32'hFFFF_FFFF, 16'd2);
    waitIdle("wrap_complete");

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
